llr_in_buffer: RTL and testbench
================================

# llr_in_buffer

Channel-LLR input stage of the polar SC decoder. Accepts one wide signed channel LLR per cycle, saturates it to the decoder word width, and collects a frame of N values in a ping-pong register buffer. Once a frame is complete, it presents the first-stage operand pairs (llr[i], llr[i+N/2]) to the downstream LLR processing element over a valid/ready handshake. While that frame drains, the next frame fills the other bank.

## Interface
- DATA_WIDTH, 8: signed LLR width delivered to the PE.
- IN_WIDTH, 12: signed channel LLR width; must be ≥ DATA_WIDTH.
- N, 8: code length; power of two, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  in_data valid.
- in_ready  output  1  buffer can accept a sample.
- in_data  input  IN_WIDTH  signed channel LLR, in natural index order 0..N-1.
- out_valid  output  1  pair valid.
- out_ready  input  1  PE accepts pair.
- out_a  output  DATA_WIDTH  signed llr[i].
- out_b  output  DATA_WIDTH  signed llr[i+N/2].
- out_idx  output  log2(N/2) (min 1)  pair index i.
- out_last  output  1  high with pair i = N/2-1.

## Operation
- Storage: two banks (0, 1), each holding N DATA_WIDTH registers, plus a full flag per bank.
- Write pointers: wsel (bank being filled) and wcnt (0..N-1).
- Read pointers: rsel (bank being drained) and rcnt (0..N/2-1).
- Saturation: values above +(2^(DATA_WIDTH-1)-1) clamp to that value.
- Saturation: values below −(2^(DATA_WIDTH-1)-1) clamp to that value.
  - The range is symmetric, so the most-negative code is never stored and the PE can negate safely.
  - In range: the value is truncated to DATA_WIDTH with no change in value.
- Write side:
  - in_ready = !full[wsel].
  - On in_valid && in_ready: bank[wsel][wcnt] <= sat(in_data) and wcnt increments.
  - When wcnt = N-1 on that accept: full[wsel] <= 1, wcnt <= 0, and wsel toggles.
  - in_valid while in_ready is low is ignored; no sample is lost and none is stored.
- Read side:
  - out_valid = full[rsel].
  - out_a = bank[rsel][rcnt]; out_b = bank[rsel][rcnt+N/2].
  - out_idx = rcnt; out_last = out_valid && (rcnt = N/2-1).
  - When out_valid is low, out_a, out_b and out_idx show the current, non-valid bank contents; only out_valid qualifies them.
  - On out_valid && out_ready: rcnt increments. When out_last is also high: full[rsel] <= 0, rcnt <= 0, and rsel toggles.
- Simultaneous events: fill of one bank and drain of the other proceed independently in the same cycle.
  - When a bank is freed and the writer is stalled on that same bank in the same cycle, in_ready rises the next cycle.
- Both banks full: in_ready = 0 until a frame fully drains.
- Reset, also mid-frame:
  - All registers are cleared: banks, full flags, wsel, rsel, wcnt and rcnt go to 0.
  - Any partial or undrained frame is discarded.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_a = out_b = 0, out_idx = 0, out_last = 0.

## Timing
- Write: a sample accepted at edge k is stored at edge k.
- Frame-complete latency: when sample N-1 is accepted at edge k, out_valid = 1 in the cycle following edge k, with pair 0 presented.
- Read throughput: one pair per cycle while out_ready = 1, so a frame drains in N/2 cycles minimum.
- Input throughput: sustained one sample per cycle when the PE drains at least N/2 pairs per N cycles; the ping-pong hides drain time.
- Handshake: out_a, out_b, out_idx and out_last are stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- in_ready depends only on registered state, with no combinational path from in_valid.
- out_valid depends only on registered state, with no combinational path from out_ready.

## Test plan
All cases use N=8, DATA_WIDTH=8, IN_WIDTH=12.
- Reset then idle:
  - Expect in_ready = 1, out_valid = 0 and all data outputs 0.
- Single frame with out_ready = 1, in_data = 1..8:
  - Expect out_valid one cycle after the 8th accept.
  - Expect pairs (1,5), (2,6), (3,7), (4,8) with idx 0..3, and out_last only on (4,8).
- Saturation:
  - in_data = 300, −300, 127, −127, −128, 0, 2047, −2048 must be stored as 127, −127, 127, −127, −127, 0, 127, −127.
  - Expect pairs (127,−127), (−127,0), (127,127), (−127,−127).
- Backpressure:
  - out_ready = 0 while three frames are offered back to back.
  - Expect 16 samples accepted, then in_ready = 0 with outputs stable.
  - Release out_ready: frame 0 pairs emerge, in_ready rises one cycle after frame 0's last handshake, and frame 2 then fills in order.
- Concurrent fill/drain:
  - Continuous in_valid over 4 frames with out_ready toggling 1,0,1,0.
  - Expect in_ready to stay 1 throughout.
  - Expect all 16 pairs in order, each matching the frame that produced it.
- Reset mid-operation:
  - Assert rst_n = 0 after 5 samples of frame 1, while frame 0 is at pair 2.
  - Expect out_valid to fall immediately.
  - After release, a new frame 10..17 yields (10,14), (11,15), (12,16), (13,17) only.

Source files
------------

// File: rtl/llr_in_buffer.sv
// Channel-LLR input stage: saturates wide channel LLRs and collects frames in a ping-pong
// register buffer, then presents first-stage operand pairs (llr[i], llr[i+N/2]) downstream.
module llr_in_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IN_WIDTH   = 12,
   parameter int unsigned N          = 8,
   localparam int unsigned IDX_W     = (N > 2) ? $clog2(N / 2) : 1,
   localparam int unsigned CNT_W     = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_WIDTH-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_a,
   output logic [DATA_WIDTH-1:0] out_b,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last
);

   // Symmetric clamp range so the most-negative code never reaches the PE.
   localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [IN_WIDTH-1:0] SAT_LO = -SAT_HI;

   logic [DATA_WIDTH-1:0] bank_q [2][N];
   logic [DATA_WIDTH-1:0] bank_d [2][N];
   logic [1:0]            full_q, full_d;
   logic                  wsel_q, wsel_d;
   logic                  rsel_q, rsel_d;
   logic [CNT_W-1:0]      wcnt_q, wcnt_d;
   logic [IDX_W-1:0]      rcnt_q, rcnt_d;

   logic signed [IN_WIDTH-1:0] in_s;
   logic [DATA_WIDTH-1:0]      sat_val;
   logic [CNT_W-1:0]           rd_a_idx, rd_b_idx;
   logic                       wr_fire, rd_fire, wr_last, rd_last;

   assign in_s = $signed(in_data);

   always_comb begin
      if (in_s > SAT_HI) begin
         sat_val = SAT_HI[DATA_WIDTH-1:0];
      end else if (in_s < SAT_LO) begin
         sat_val = SAT_LO[DATA_WIDTH-1:0];
      end else begin
         sat_val = in_s[DATA_WIDTH-1:0];
      end
   end

   assign rd_a_idx = CNT_W'(rcnt_q);
   assign rd_b_idx = CNT_W'(rcnt_q) + CNT_W'(N / 2);

   assign in_ready  = ~full_q[wsel_q];
   assign out_valid = full_q[rsel_q];
   assign out_a     = bank_q[rsel_q][rd_a_idx];
   assign out_b     = bank_q[rsel_q][rd_b_idx];
   assign out_idx   = rcnt_q;
   assign rd_last   = (rcnt_q == IDX_W'(N / 2 - 1));
   assign out_last  = out_valid & rd_last;

   assign wr_fire = in_valid & in_ready;
   assign rd_fire = out_valid & out_ready;
   assign wr_last = (wcnt_q == CNT_W'(N - 1));

   // Writer and reader always address different banks when both fire, so their updates to
   // full_d never collide.
   always_comb begin
      bank_d = bank_q;
      full_d = full_q;
      wsel_d = wsel_q;
      rsel_d = rsel_q;
      wcnt_d = wcnt_q;
      rcnt_d = rcnt_q;

      if (wr_fire) begin
         bank_d[wsel_q][wcnt_q] = sat_val;
         if (wr_last) begin
            full_d[wsel_q] = 1'b1;
            wcnt_d         = '0;
            wsel_d         = ~wsel_q;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end

      if (rd_fire) begin
         if (rd_last) begin
            full_d[rsel_q] = 1'b0;
            rcnt_d         = '0;
            rsel_d         = ~rsel_q;
         end else begin
            rcnt_d = rcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < int'(N); i++) begin
               bank_q[b][i] <= '0;
            end
         end
         full_q <= '0;
         wsel_q <= 1'b0;
         rsel_q <= 1'b0;
         wcnt_q <= '0;
         rcnt_q <= '0;
      end else begin
         bank_q <= bank_d;
         full_q <= full_d;
         wsel_q <= wsel_d;
         rsel_q <= rsel_d;
         wcnt_q <= wcnt_d;
         rcnt_q <= rcnt_d;
      end
   end

endmodule

// File: tb/tb_llr_in_buffer.sv
// Self-checking bench for llr_in_buffer: frame-level reference model feeding a pair scoreboard,
// with an independent output monitor that compares every presented pair and handshake flag.
module tb_llr_in_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_a;
   logic [7:0]  out_b;
   logic [1:0]  out_idx;
   logic        out_last;

   llr_in_buffer #(
      .DATA_WIDTH (8),
      .IN_WIDTH   (12),
      .N          (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Scoreboard of expected pairs; written only by the input model, read by the monitor.
   int exp_a [4096];
   int exp_b [4096];
   int exp_idx [4096];
   int exp_last [4096];
   int wr_ptr = 0;
   int wr_prev = 0;
   int rd_ptr = 0;
   int total_acc = 0;
   int pairs_seen = 0;
   int stall_cnt = 0;
   int rdy_mode = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 127) return 127;
      if (v < -127) return -127;
      return v;
   endfunction

   // Input-side reference model: collects accepted samples into frames.
   initial begin
      int frame [8];
      int fill;
      fill = 0;
      forever begin
         @(negedge clk);
         wr_prev = wr_ptr;
         if (!rst_n) begin
            fill = 0;
         end else if (in_valid && in_ready) begin
            frame[fill] = sat(int'($signed(in_data)));
            fill++;
            total_acc++;
            if (fill == 8) begin
               for (int i = 0; i < 4; i++) begin
                  exp_a[wr_ptr % 4096]    = frame[i];
                  exp_b[wr_ptr % 4096]    = frame[i + 4];
                  exp_idx[wr_ptr % 4096]  = i;
                  exp_last[wr_ptr % 4096] = (i == 3) ? 1 : 0;
                  wr_ptr++;
               end
               fill = 0;
            end
         end
      end
   end

   // Output monitor: flags against model occupancy, pair data against the scoreboard.
   initial begin
      int outstanding;
      int frames;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            rd_ptr = wr_ptr;
            pairs_seen = 0;
         end else begin
            outstanding = wr_prev - rd_ptr;
            frames = (outstanding + 3) / 4;
            chk("out_valid", int'(out_valid), (outstanding > 0) ? 1 : 0);
            chk("in_ready", int'(in_ready), (frames < 2) ? 1 : 0);
            if (out_valid && outstanding > 0) begin
               chk("out_a", int'($signed(out_a)), exp_a[rd_ptr % 4096]);
               chk("out_b", int'($signed(out_b)), exp_b[rd_ptr % 4096]);
               chk("out_idx", int'(out_idx), exp_idx[rd_ptr % 4096]);
               chk("out_last", int'(out_last), exp_last[rd_ptr % 4096]);
               if (out_ready) begin
                  rd_ptr++;
                  pairs_seen++;
               end
            end
         end
      end
   end

   // out_ready pattern generator: 0 always ready, 1 never, 2 toggle, 3 random.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(1));
         endcase
      end
   end

   task automatic send(input int v);
      int n;
      logic acc;
      in_valid = 1'b1;
      in_data = 12'(v);
      n = 0;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) stall_cnt++;
         n++;
      end while (!acc && n < 200);
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (rd_ptr != wr_ptr && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_complete", rd_ptr, wr_ptr);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 1);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_out_a"}, int'(out_a), 0);
      chk({tag, "_out_b"}, int'(out_b), 0);
      chk({tag, "_out_idx"}, int'(out_idx), 0);
      chk({tag, "_out_last"}, int'(out_last), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int sat_vals [8];
      int base;
      sat_vals = '{300, -300, 127, -127, -128, 0, 2047, -2048};
      rst_n = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      rdy_mode = 0;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("rst");
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1 chk_reset_outputs("idle");

      // Single frame 1..8
      for (int i = 1; i <= 8; i++) send(i);
      wait_drain();

      // Saturation boundaries
      foreach (sat_vals[i]) send(sat_vals[i]);
      wait_drain();

      // Backpressure: three frames offered while the PE stalls
      rdy_mode = 1;
      base = total_acc;
      fork
         begin
            for (int i = 0; i < 24; i++) send(100 + i);
         end
         begin
            repeat (30) begin
               @(posedge clk);
               #1;
            end
            chk("bp_accepted", total_acc - base, 16);
            chk("bp_in_ready", int'(in_ready), 0);
            rdy_mode = 0;
         end
      join
      wait_drain();

      // Concurrent fill/drain with toggling out_ready
      rdy_mode = 2;
      stall_cnt = 0;
      for (int i = 0; i < 32; i++) send(int'($urandom_range(4095)));
      chk("concurrent_stalls", stall_cnt, 0);
      wait_drain();

      // Random gaps and random backpressure
      rdy_mode = 3;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(2) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         send(int'($urandom_range(4095)));
      end
      rdy_mode = 0;
      wait_drain();

      // Reset mid-operation: frame 0 at pair 2, frame 1 holding 5 samples
      rdy_mode = 1;
      for (int i = 0; i < 13; i++) send(20 + i);
      in_valid = 1'b0;
      rdy_mode = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rdy_mode = 1;
      chk("mid_out_idx", int'(out_idx), 2);
      chk("mid_out_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      rdy_mode = 0;
      for (int i = 10; i <= 17; i++) send(i);
      wait_drain();
      chk("post_reset_pairs", pairs_seen, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
